// File: rtl/fetch_select.sv
// rtl/fetch_select.sv - BIOS/process fetch-ownership selector with one-cycle switch bubble
//
// Purpose : selects whether the BIOS ROM or program memory supplies the
//           instruction stream, keeps a separate PC for each owner, and
//           inserts a single bubble cycle whenever ownership changes hands.
//           Ownership only changes at an instruction retirement.
// Ports   : clk, rst             - clock, synchronous active-high reset
//           controll             - 1 = BIOS should execute, 0 = process
//           bios_instruction     - BIOS ROM word at pc
//           mem_instruction      - program memory word at pc
//           pc_next, pc_we       - next PC and retire strobe from the core
//           stall                - freeze all state this cycle
//           pc                   - fetch address to both memories
//           instruction          - registered fetched word (NOP in bubbles)
//           inst_valid           - instruction is a real fetched word
//           done_inst            - one-cycle pulse after each retirement
//           proc_pc              - saved or live process PC
//           switching            - high during a switch bubble cycle
//           switch_count         - completed ownership switches (saturating)
//
// Instruction words are big-endian numbered [0:31]. They are carried here on
// [31:0] vectors: vector bit 31 is the word's bit 0. Values pass through
// unchanged, so only the numbering differs.
module fetch_select #(
    parameter logic [31:0] BIOS_RESET_PC = 32'd0,
    parameter logic [31:0] PROC_RESET_PC = 32'd0,
    parameter logic [31:0] NOP_WORD      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        controll,
    input  logic [31:0] bios_instruction,
    input  logic [31:0] mem_instruction,
    input  logic [31:0] pc_next,
    input  logic        pc_we,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        inst_valid,
    output logic        done_inst,
    output logic [31:0] proc_pc,
    output logic        switching,
    output logic [15:0] switch_count
);

    typedef enum logic [1:0] {
        S_BIOS    = 2'd0,
        S_TO_PROC = 2'd1,
        S_PROC    = 2'd2,
        S_TO_BIOS = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] bios_pc;
    logic        retire;

    // Retirement needs a real instruction on the bus; pc_we during a bubble
    // (inst_valid=0) is ignored.
    assign retire = pc_we & ~stall & inst_valid;

    // During a bubble the address already points at the incoming owner, so
    // the word captured when the bubble ends belongs to the new owner.
    assign pc = (state == S_BIOS || state == S_TO_BIOS) ? bios_pc : proc_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_BIOS;
            bios_pc      <= BIOS_RESET_PC;
            proc_pc      <= PROC_RESET_PC;
            instruction  <= NOP_WORD;
            inst_valid   <= 1'b0;
            done_inst    <= 1'b0;
            switching    <= 1'b0;
            switch_count <= 16'd0;
        end else if (stall) begin
            done_inst <= 1'b0;
        end else begin
            done_inst <= retire;
            case (state)
                S_BIOS: begin
                    if (retire) begin
                        bios_pc <= pc_next;
                    end
                    // A controll change without a retirement simply waits
                    // here until the in-flight instruction retires.
                    if (retire && !controll) begin
                        state       <= S_TO_PROC;
                        instruction <= NOP_WORD;
                        inst_valid  <= 1'b0;
                        switching   <= 1'b1;
                    end else begin
                        instruction <= bios_instruction;
                        inst_valid  <= 1'b1;
                    end
                end
                S_PROC: begin
                    if (retire) begin
                        proc_pc <= pc_next;
                    end
                    if (retire && controll) begin
                        state       <= S_TO_BIOS;
                        instruction <= NOP_WORD;
                        inst_valid  <= 1'b0;
                        switching   <= 1'b1;
                    end else begin
                        instruction <= mem_instruction;
                        inst_valid  <= 1'b1;
                    end
                end
                S_TO_PROC: begin
                    state       <= S_PROC;
                    instruction <= mem_instruction;
                    inst_valid  <= 1'b1;
                    switching   <= 1'b0;
                    if (switch_count != 16'hFFFF) begin
                        switch_count <= switch_count + 16'd1;
                    end
                end
                S_TO_BIOS: begin
                    state       <= S_BIOS;
                    instruction <= bios_instruction;
                    inst_valid  <= 1'b1;
                    switching   <= 1'b0;
                    if (switch_count != 16'hFFFF) begin
                        switch_count <= switch_count + 16'd1;
                    end
                end
                default: begin
                    state <= S_BIOS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_select.sv
// tb/tb_fetch_select.sv - directed self-checking bench for fetch_select
module tb_fetch_select;

    localparam logic [31:0] BIOS_RST = 32'h0000_0100;
    localparam logic [31:0] PROC_RST = 32'h0000_2000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        controll;
    logic [31:0] bios_instruction;
    logic [31:0] mem_instruction;
    logic [31:0] pc_next;
    logic        pc_we;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        done_inst;
    logic [31:0] proc_pc;
    logic        switching;
    logic [15:0] switch_count;

    int checks;
    int errors;

    fetch_select #(
        .BIOS_RESET_PC(BIOS_RST),
        .PROC_RESET_PC(PROC_RST),
        .NOP_WORD     (NOP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .controll        (controll),
        .bios_instruction(bios_instruction),
        .mem_instruction (mem_instruction),
        .pc_next         (pc_next),
        .pc_we           (pc_we),
        .stall           (stall),
        .pc              (pc),
        .instruction     (instruction),
        .inst_valid      (inst_valid),
        .done_inst       (done_inst),
        .proc_pc         (proc_pc),
        .switching       (switching),
        .switch_count    (switch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        controll = 1'b1;
        stall = 1'b0;
        pc_we = 1'b0;
        pc_next = 32'd0;
        bios_instruction = 32'hA5A5_0001;
        mem_instruction  = 32'hC0DE_0001;

        // Reset state
        step();
        step();
        chk("rst_valid",  {31'd0, inst_valid}, 32'd0);
        chk("rst_instr",  instruction, NOP);
        chk("rst_done",   {31'd0, done_inst}, 32'd0);
        chk("rst_switch", {31'd0, switching}, 32'd0);
        chk("rst_count",  {16'd0, switch_count}, 32'd0);
        chk("rst_pc",     pc, BIOS_RST);
        chk("rst_procpc", proc_pc, PROC_RST);

        // First valid BIOS fetch one cycle after reset release
        rst = 1'b0;
        step();
        chk("first_valid", {31'd0, inst_valid}, 32'd1);
        chk("first_instr", instruction, 32'hA5A5_0001);
        chk("first_pc",    pc, BIOS_RST);

        // BIOS retire with controll=1: stays in BIOS
        pc_we = 1'b1;
        pc_next = 32'd8;
        step();
        chk("bios_ret_done", {31'd0, done_inst}, 32'd1);
        chk("bios_ret_pc",   pc, 32'd8);
        chk("bios_ret_sw",   {31'd0, switching}, 32'd0);
        pc_we = 1'b0;
        step();
        chk("bios_done_clr", {31'd0, done_inst}, 32'd0);

        // BIOS retire with controll=0: switch to process
        controll = 1'b0;
        pc_we = 1'b1;
        pc_next = 32'd111;
        step();
        chk("to_proc_done",  {31'd0, done_inst}, 32'd1);
        chk("to_proc_sw",    {31'd0, switching}, 32'd1);
        chk("to_proc_pc",    pc, PROC_RST);
        chk("to_proc_ppc",   proc_pc, PROC_RST);
        chk("to_proc_valid", {31'd0, inst_valid}, 32'd0);
        chk("to_proc_instr", instruction, NOP);
        // pc_we held high during the bubble must be ignored
        pc_next = 32'd555;
        step();
        chk("bubble_done",  {31'd0, done_inst}, 32'd0);
        chk("proc_sw",      {31'd0, switching}, 32'd0);
        chk("proc_pc_keep", pc, PROC_RST);
        chk("proc_count",   {16'd0, switch_count}, 32'd1);
        chk("proc_valid",   {31'd0, inst_valid}, 32'd1);
        chk("proc_instr",   instruction, 32'hC0DE_0001);
        pc_we = 1'b0;

        // controll rises while stalled (with pc_we) for 3 cycles: nothing moves
        controll = 1'b1;
        stall = 1'b1;
        pc_we = 1'b1;
        pc_next = 32'd42;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc",    pc, PROC_RST);
            chk("stall_sw",    {31'd0, switching}, 32'd0);
            chk("stall_done",  {31'd0, done_inst}, 32'd0);
            chk("stall_count", {16'd0, switch_count}, 32'd1);
        end
        stall = 1'b0;
        bios_instruction = 32'hB105_0002;
        step();
        chk("to_bios_done", {31'd0, done_inst}, 32'd1);
        chk("to_bios_ppc",  proc_pc, 32'd42);
        chk("to_bios_sw",   {31'd0, switching}, 32'd1);
        chk("to_bios_pc",   pc, 32'd111);
        pc_we = 1'b0;
        step();
        chk("bios2_pc",    pc, 32'd111);
        chk("bios2_sw",    {31'd0, switching}, 32'd0);
        chk("bios2_count", {16'd0, switch_count}, 32'd2);
        chk("bios2_instr", instruction, 32'hB105_0002);
        chk("bios2_valid", {31'd0, inst_valid}, 32'd1);

        // Reset asserted during S_TO_PROC
        controll = 1'b0;
        pc_we = 1'b1;
        pc_next = 32'd200;
        step();
        chk("pre_rst_sw", {31'd0, switching}, 32'd1);
        chk("pre_rst_pc", pc, 32'd42);
        pc_we = 1'b0;
        rst = 1'b1;
        stall = 1'b1;
        step();
        chk("mid_rst_sw",    {31'd0, switching}, 32'd0);
        chk("mid_rst_pc",    pc, BIOS_RST);
        chk("mid_rst_count", {16'd0, switch_count}, 32'd0);
        chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("mid_rst_ppc",   proc_pc, PROC_RST);
        rst = 1'b0;
        stall = 1'b0;
        controll = 1'b1;
        step();
        chk("post_rst_valid", {31'd0, inst_valid}, 32'd1);

        // Saturation of switch_count
        @(negedge clk);
        force dut.switch_count = 16'hFFFF;
        #1;
        release dut.switch_count;
        #1;
        chk("sat_forced", {16'd0, switch_count}, 32'h0000_FFFF);
        controll = 1'b0;
        pc_we = 1'b1;
        pc_next = 32'd300;
        step();
        chk("sat_sw", {31'd0, switching}, 32'd1);
        pc_we = 1'b0;
        step();
        chk("sat_count", {16'd0, switch_count}, 32'h0000_FFFF);
        chk("sat_sw_clr", {31'd0, switching}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_select.md
FETCH_SELECT -- requirements
Module: fetch_select

Interface
REQ-001 Parameter BIOS_RESET_PC, default 32'd0, BIOS fetch address after reset.
REQ-002 Parameter PROC_RESET_PC, default 32'd0, process fetch address after reset.
REQ-003 Parameter NOP_WORD, default 32'h0000_0000, instruction driven during bubbles.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 controll  input  1  BIOS ownership request from the BIOS block: 1 = BIOS executes, 0 = process executes.
REQ-007 bios_instruction  input  32  BIOS ROM word at the current pc, big-endian bit order [0:31].
REQ-008 mem_instruction  input  32  program memory word at the current pc, big-endian bit order [0:31].
REQ-009 pc_next  input  32  next PC computed by the processor for the instruction in flight.
REQ-010 pc_we  input  1  processor retires the current instruction this cycle.
REQ-011 stall  input  1  freeze all state this cycle.
REQ-012 pc  output  32  fetch address, presented to both the BIOS ROM and program memory.
REQ-013 instruction  output  32  registered fetched word, big-endian [0:31].
REQ-014 inst_valid  output  1  instruction holds a real fetched word (0 = bubble).
REQ-015 done_inst  output  1  registered one-cycle retirement pulse, consumed by the BIOS block.
REQ-016 proc_pc  output  32  saved or live process PC.
REQ-017 switching  output  1  high during a switch bubble cycle.
REQ-018 switch_count  output  16  number of completed ownership switches.

Function
REQ-019 The FSM SHALL have states S_BIOS, S_TO_PROC, S_PROC and S_TO_BIOS, and SHALL hold registers bios_pc and proc_pc.
REQ-020 retire = pc_we & ~stall & inst_valid; pc_we while inst_valid=0 SHALL be ignored.
REQ-021 pc SHALL equal bios_pc in S_BIOS and S_TO_BIOS, and proc_pc in S_PROC and S_TO_PROC (combinational from the registers).
REQ-022 S_BIOS on retire: if controll=0, bios_pc<=pc_next and next state is S_TO_PROC; otherwise bios_pc<=pc_next and the FSM stays in S_BIOS.
REQ-023 S_PROC on retire: if controll=1, proc_pc<=pc_next and next state is S_TO_BIOS; otherwise proc_pc<=pc_next and the FSM stays in S_PROC.
REQ-024 A controll change without retire SHALL be held pending; no instruction is ever abandoned mid-flight.
REQ-025 S_TO_PROC and S_TO_BIOS SHALL last exactly one non-stalled cycle, then go to S_PROC and S_BIOS respectively; controll is ignored in these states.
REQ-026 In S_TO_PROC and S_TO_BIOS: instruction<=NOP_WORD, inst_valid<=0, switching=1, and switch_count increments, saturating at 16'hFFFF.
REQ-027 In S_BIOS on a non-stalled cycle: instruction<=bios_instruction and inst_valid<=1. In S_PROC on a non-stalled cycle: instruction<=mem_instruction and inst_valid<=1.
REQ-028 done_inst SHALL be 1 in the cycle after each retire, and 0 otherwise; this includes the retire that triggers a switch.
REQ-029 When stall=1, state, PCs, instruction, inst_valid, switch_count and switching SHALL hold; done_inst<=0.
REQ-030 PC arithmetic is none: pc_next is stored verbatim, with no wrap handling inside the block.

Reset
REQ-031 When rst=1 at posedge, the block SHALL load: state=S_BIOS, bios_pc=BIOS_RESET_PC, proc_pc=PROC_RESET_PC, instruction=NOP_WORD, inst_valid=0, done_inst=0, switching=0, switch_count=0.
REQ-032 rst SHALL override stall and any pending switch, including when asserted in S_TO_PROC or S_TO_BIOS.
REQ-033 The first valid instruction SHALL appear one cycle after rst deasserts, fetched from BIOS_RESET_PC.

Verification
REQ-034 Reset, then controll=1, bios_instruction=32'hA5A5_0001 -> cycle 1: inst_valid=1, instruction=32'hA5A5_0001, pc=0.
REQ-035 In S_BIOS, controll=0, retire with pc_next=111 -> done_inst pulse; bubble with switching=1; pc=proc_pc=0; mem_instruction then captured; bios_pc=111; switch_count=1.
REQ-036 In S_PROC, controll rises while stall=1 for 3 cycles, then retire with pc_next=42 -> no switch during the stall; after retire proc_pc=42, S_TO_BIOS, pc=111.
REQ-037 pc_we=1 during the bubble cycle -> no done_inst and no PC change.
REQ-038 Assert rst in S_TO_PROC -> next cycle S_BIOS, pc=BIOS_RESET_PC, switch_count=0, inst_valid=0.
REQ-039 Force switch_count=16'hFFFF and perform a switch -> switch_count remains 16'hFFFF.
